rv_dm_master: RTL and testbench

//  Data-memory bus initiator: drives the CPU-side dm_* interface (addr, store data, byte select,

---
 rtl/rv_dm_master.sv | 181 ++++++++++++++++++
 tb/tb_rv_dm_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_dm_master.sv
// Data-memory bus initiator: turns one command/response transaction into a dm_* strobe cycle.
// Optional done-wait watchdog enabled by defining RV_DM_MASTER_TIMEOUT_EN.
module rv_dm_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_signed_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_store_o,
  output logic        dm_load_o,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_store_done_i,
  input  logic        dm_load_done_i,
  input  logic        dm_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state, state_next;
  logic        accept, cmd_bad, done_hit, timeout_hit;
  logic        we_q, signed_q;
  logic [1:0]  size_q, off_q;
  logic [3:0]  sel_new;
  logic [31:0] data_new, shifted, load_ext;

  assign accept      = (state == S_IDLE) && cmd_valid_i;
  assign cmd_ready_o = (state == S_IDLE);
  assign rsp_valid_o = (state == S_RESP);
  assign done_hit    = (state == S_WAIT) && (we_q ? dm_store_done_i : dm_load_done_i);

  always_comb begin
    unique case (cmd_size_i)
      2'b00:   cmd_bad = 1'b0;
      2'b01:   cmd_bad = cmd_addr_i[0];
      2'b10:   cmd_bad = |cmd_addr_i[1:0];
      default: cmd_bad = 1'b1;
    endcase
  end

  // Lane select and replicated store data, computed from the command at accept time.
  always_comb begin
    sel_new  = 4'b1111;
    data_new = cmd_wdata_i;
    unique case (cmd_size_i)
      2'b00: begin
        sel_new  = 4'b0001 << cmd_addr_i[1:0];
        data_new = {4{cmd_wdata_i[7:0]}};
      end
      2'b01: begin
        sel_new  = cmd_addr_i[1] ? 4'b1100 : 4'b0011;
        data_new = {2{cmd_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = dm_data_l_i >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

`ifdef RV_DM_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  // Keeps the watchdog limit referenced when the watchdog is compiled out.
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    dm_store_o = 1'b0;
    dm_load_o  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid_i) state_next = cmd_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (dm_ready_i) begin
          dm_store_o = we_q;
          dm_load_o  = !we_q;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_hit || timeout_hit) state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, bus drive registers and response capture; a done beats an expiring watchdog.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q             <= 1'b0;
      signed_q         <= 1'b0;
      size_q           <= 2'b00;
      off_q            <= 2'b00;
      dm_addr_o        <= '0;
      dm_data_s_o      <= '0;
      dm_data_select_o <= '0;
      rsp_rdata_o      <= '0;
      rsp_err_o        <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= cmd_we_i;
        signed_q <= cmd_signed_i;
        size_q   <= cmd_size_i;
        off_q    <= cmd_addr_i[1:0];
        if (cmd_bad) begin
          rsp_err_o   <= 1'b1;
          rsp_rdata_o <= ERR_RDATA;
        end else begin
          dm_addr_o        <= {cmd_addr_i[31:2], 2'b00};
          dm_data_s_o      <= data_new;
          dm_data_select_o <= sel_new;
        end
      end
      if (done_hit) begin
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= we_q ? 32'h0 : load_ext;
      end else if (timeout_hit) begin
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= ERR_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_rv_dm_master.sv
// Self-checking bench for rv_dm_master: vector table driven through a scoreboard, plus
// hand-written reset-in-WAIT and (with RV_DM_MASTER_TIMEOUT_EN) watchdog sequences.
module tb_rv_dm_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_signed;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dm_addr, dm_data_s, dm_data_l;
  logic [3:0]  dm_sel;
  logic        dm_store, dm_load, dm_store_done, dm_load_done, dm_ready;

  always #5 clk = ~clk;

  rv_dm_master #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .cmd_signed_i(cmd_signed),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .dm_addr_o(dm_addr), .dm_data_s_o(dm_data_s), .dm_data_select_o(dm_sel),
    .dm_store_o(dm_store), .dm_load_o(dm_load), .dm_data_l_i(dm_data_l),
    .dm_store_done_i(dm_store_done), .dm_load_done_i(dm_load_done), .dm_ready_i(dm_ready)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] wdata;
    int          rdy_lat;
    int          done_lat;
    int          rsp_hold;
    bit          xdone;
    bit          no_done;
    int          lat;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] bus_addr;
    logic [3:0]  sel;
    logic [31:0] data_s;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  int   n_checks = 0, n_bad = 0;
  int   cyc = 0, strobe_cnt = 0, strobe_cyc = 0;
  vec_t bus_q[$];
  rsp_t rsp_q[$];
  vec_t tbl[$];
  vec_t mon_b;
  rsp_t mon_r;

  // Responder model: word memory, programmable done latency, optional wrong-kind done.
  logic [31:0] mem [256];
  bit          pend, pend_we, done_en, xdone_en;
  int          pend_ctr, done_lat_cfg;
  logic        hit;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_we  <= 1'b0;
      pend_ctr <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h80] <= 32'h80011234;
    end else begin
      if (pend) begin
        if (hit) pend <= 1'b0;
        else if (pend_ctr > 0) pend_ctr <= pend_ctr - 1;
      end
      if ((dm_store || dm_load) && dm_ready) begin
        pend     <= 1'b1;
        pend_we  <= dm_store;
        pend_ctr <= done_lat_cfg;
        if (dm_store)
          for (int i = 0; i < 4; i++)
            if (dm_sel[i]) mem[dm_addr[9:2]][8*i +: 8] <= dm_data_s[8*i +: 8];
      end
    end
  end

  assign hit           = pend && done_en && (pend_ctr == 0);
  assign dm_store_done = (pend_we && hit) || (!pend_we && pend && xdone_en);
  assign dm_load_done  = (!pend_we && hit) || (pend_we && pend && xdone_en);
  assign dm_data_l     = mem[dm_addr[9:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_bad++;
    $display("FAIL %s: got no event within budget, want event", name);
  endtask

  function automatic vec_t mk(bit we, logic [31:0] addr, logic [1:0] size, bit sgn,
                              logic [31:0] wdata, int rdy, int dly, int hold, bit xd, bit nd,
                              int lat, logic [31:0] rdata, bit err, logic [31:0] baddr,
                              logic [3:0] sel, logic [31:0] ds);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
    v.rdy_lat = rdy; v.done_lat = dly; v.rsp_hold = hold; v.xdone = xd; v.no_done = nd;
    v.lat = lat; v.rdata = rdata; v.err = err; v.bus_addr = baddr; v.sel = sel; v.data_s = ds;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    check1({tag, " cmd_ready"}, cmd_ready, 1'b1);
    check1({tag, " rsp_valid"}, rsp_valid, 1'b0);
    check1({tag, " rsp_err"}, rsp_err, 1'b0);
    check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    check1({tag, " dm_store"}, dm_store, 1'b0);
    check1({tag, " dm_load"}, dm_load, 1'b0);
    check({tag, " dm_addr"}, dm_addr, 32'h0);
    check({tag, " dm_data_s"}, dm_data_s, 32'h0);
    check({tag, " dm_sel"}, {28'h0, dm_sel}, 32'h0);
  endtask

  // Bus and response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_store || dm_load) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        check1("strobe needs ready", dm_ready, 1'b1);
        if (bus_q.size() == 0) begin
          n_checks++;
          n_bad++;
          $display("FAIL unexpected strobe: got store=%0b load=%0b addr=%h, want none",
                   dm_store, dm_load, dm_addr);
        end else begin
          mon_b = bus_q.pop_front();
          check1("strobe store", dm_store, mon_b.we);
          check1("strobe load", dm_load, !mon_b.we);
          check("bus addr", dm_addr, mon_b.bus_addr);
          check("bus sel", {28'h0, dm_sel}, {28'h0, mon_b.sel});
          if (mon_b.we) check("bus store data", dm_data_s, mon_b.data_s);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_bad++;
          $display("FAIL unexpected response: got rdata=%h, want none", rsp_rdata);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp rdata", rsp_rdata, mon_r.rdata);
          check1("rsp err", rsp_err, mon_r.err);
        end
      end
    end
  end

  task automatic run(input vec_t v, input int idx);
    int    t, n, s0;
    bit    has_bus;
    rsp_t  r;
    string p;
    p = $sformatf("v%0d", idx);
    has_bus = !v.err || v.no_done;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin expire({p, " cmd_ready"}); return; end
    r.rdata = v.rdata;
    r.err   = v.err;
    rsp_q.push_back(r);
    if (has_bus) bus_q.push_back(v);
    cmd_valid  = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_size = v.size;
    cmd_signed = v.sgn; cmd_wdata = v.wdata;
    dm_ready   = (v.rdy_lat == 0);
    rsp_ready  = (v.rsp_hold == 0);
    done_lat_cfg = v.done_lat; done_en = !v.no_done; xdone_en = v.xdone;
    t  = cyc;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    repeat (v.rdy_lat) begin @(posedge clk); #1; end
    dm_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin expire({p, " rsp_valid"}); return; end
    check({p, " rsp latency"}, cyc - t, v.lat);
    repeat (v.rsp_hold) begin
      check1({p, " hold rsp_valid"}, rsp_valid, 1'b1);
      check({p, " hold rdata"}, rsp_rdata, v.rdata);
      check1({p, " hold err"}, rsp_err, v.err);
      check1({p, " hold cmd_ready"}, cmd_ready, 1'b0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check1({p, " rsp dropped"}, rsp_valid, 1'b0);
    check1({p, " cmd_ready back"}, cmd_ready, 1'b1);
    check({p, " strobe count"}, strobe_cnt - s0, has_bus ? 1 : 0);
    if (has_bus) check({p, " strobe cycle"}, strobe_cyc - t, 1 + v.rdy_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got no finish, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t rv;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_signed = 1'b0; cmd_wdata = '0; rsp_ready = 1'b1; dm_ready = 1'b1;
    done_en = 1'b1; xdone_en = 1'b0; done_lat_cfg = 0;

    //              we addr        sz sg wdata         rdy dly hold xd nd lat rdata         err baddr       sel      data_s
    tbl.push_back(mk(1, 32'h103, 0, 0, 32'h000000A5, 0, 0, 0, 0, 0, 3, 32'h0,        0, 32'h100, 4'b1000, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 32'h103, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3, 32'h000000A5, 0, 32'h100, 4'b1000, 32'h0));
    tbl.push_back(mk(0, 32'h103, 0, 1, 32'h0,        0, 0, 0, 0, 0, 3, 32'hFFFFFFA5, 0, 32'h100, 4'b1000, 32'h0));
    tbl.push_back(mk(0, 32'h202, 1, 1, 32'h0,        0, 0, 0, 0, 0, 3, 32'hFFFF8001, 0, 32'h200, 4'b1100, 32'h0));
    tbl.push_back(mk(0, 32'h202, 1, 0, 32'h0,        0, 0, 0, 0, 0, 3, 32'h00008001, 0, 32'h200, 4'b1100, 32'h0));
    tbl.push_back(mk(0, 32'h101, 2, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h0,   4'b0000, 32'h0));
    tbl.push_back(mk(1, 32'h302, 1, 0, 32'hFFFF1234, 3, 2, 0, 0, 0, 8, 32'h0,        0, 32'h300, 4'b1100, 32'h12341234));
    tbl.push_back(mk(0, 32'h300, 2, 0, 32'h0,        0, 1, 0, 0, 0, 4, 32'h12340000, 0, 32'h300, 4'b1111, 32'h0));
    tbl.push_back(mk(1, 32'h304, 2, 0, 32'hCAFEF00D, 0, 3, 0, 1, 0, 6, 32'h0,        0, 32'h304, 4'b1111, 32'hCAFEF00D));
    tbl.push_back(mk(0, 32'h305, 0, 1, 32'h0,        0, 0, 0, 0, 0, 3, 32'hFFFFFFF0, 0, 32'h304, 4'b0010, 32'h0));
    tbl.push_back(mk(0, 32'h000, 3, 0, 32'h0,        0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h0,   4'b0000, 32'h0));
    tbl.push_back(mk(1, 32'h101, 1, 0, 32'h1234,     0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h0,   4'b0000, 32'h0));
    tbl.push_back(mk(0, 32'h306, 1, 0, 32'h0,        0, 0, 5, 0, 0, 3, 32'h0000CAFE, 0, 32'h304, 4'b1100, 32'h0));
    tbl.push_back(mk(0, 32'h200, 0, 0, 32'h0,        0, 0, 0, 0, 0, 3, 32'h00000034, 0, 32'h200, 4'b0001, 32'h0));
    tbl.push_back(mk(0, 32'h200, 2, 0, 32'h0,        0, 7, 0, 0, 0, 10, 32'h80011234, 0, 32'h200, 4'b1111, 32'h0));
`ifdef RV_DM_MASTER_TIMEOUT_EN
    tbl.push_back(mk(0, 32'h200, 2, 0, 32'h0,        0, 0, 0, 0, 1, 10, 32'hDEADBEEF, 1, 32'h200, 4'b1111, 32'h0));
`endif

    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run(tbl[i], i);

    // Reset while waiting for a done that never comes.
    done_en = 1'b0; xdone_en = 1'b0; dm_ready = 1'b1; rsp_ready = 1'b1;
    rv = mk(0, 32'h200, 2, 0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h200, 4'b1111, 32'h0);
    bus_q.push_back(rv);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h200; cmd_size = 2'b10; cmd_signed = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check1("wait no response", rsp_valid, 1'b0);
    check1("wait cmd_ready", cmd_ready, 1'b0);
    check("wait addr held", dm_addr, 32'h200);
    #2 rst_n = 1'b0;
    #1 check_reset("mid-reset");
    @(negedge clk);
    rst_n = 1'b1;
    done_en = 1'b1;
    @(posedge clk); #1;
    run(mk(0, 32'h202, 1, 1, 32'h0, 0, 0, 0, 0, 0, 3, 32'hFFFF8001, 0, 32'h200, 4'b1100, 32'h0), 99);

    check("rsp queue drained", rsp_q.size(), 0);
    check("bus queue drained", bus_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
